// File: rtl/daio_pkg.sv
// Shared types and constants for the DAIO receive framer.
//  state_t       : framer FSM states
//  STAT_*        : bit positions inside rx_status
package daio_pkg;

    localparam int unsigned STAT_W       = 4;
    localparam int unsigned STAT_CARRIER = 0;
    localparam int unsigned STAT_BIPHASE = 1;
    localparam int unsigned STAT_SYNC    = 2;
    localparam int unsigned STAT_PARITY  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        RECV = 2'd2
    } state_t;

endpackage

// File: rtl/daio_rx_framer_if.sv
// Bit stream from the phase decoder into the framer.
//  bit_valid         : strobe, all other fields valid this cycle
//  bit_in            : extracted bit
//  preamble_block/a/b: preamble detected (block start / channel 0 / channel > 0)
//  carrier_loss      : carrier lost
//  biphase_violation : missing biphase transition
// master = phase decoder, slave = framer.
interface daio_rx_framer_if;

    logic bit_valid;
    logic bit_in;
    logic preamble_block;
    logic preamble_a;
    logic preamble_b;
    logic carrier_loss;
    logic biphase_violation;

    modport master (
        output bit_valid, bit_in, preamble_block, preamble_a, preamble_b,
               carrier_loss, biphase_violation
    );

    modport slave (
        input  bit_valid, bit_in, preamble_block, preamble_a, preamble_b,
               carrier_loss, biphase_violation
    );

endinterface

// File: rtl/daio_rx_status.sv
// Sticky receive status bits; a set on the same cycle as clear wins.
//  clock, reset : clock, asynchronous active-high reset
//  set_bits     : per-bit set requests (one cycle)
//  clear        : zero all bits
//  status       : sticky status
module daio_rx_status
    import daio_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [STAT_W-1:0] set_bits,
    input  logic              clear,
    output logic [STAT_W-1:0] status
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status <= '0;
        end else begin
            status <= (clear ? '0 : status) | set_bits;
        end
    end

endmodule

// File: rtl/daio_rx_framer.sv
// DAIO receive framer: tracks block/frame/channel/bit position of the decoded
// bit stream, pulses per-channel and buffer load strobes, checks even parity
// per subframe and keeps sticky status.
//  clock, reset  : clock, asynchronous active-high reset
//  rx_enable     : receiver enable (0 forces IDLE, counters cleared)
//  parity_enable : enables the parity_error status bit
//  status_clear  : clears sticky status
//  rx            : decoder bit stream (slave side)
//  rx_status     : [0] carrier [1] biphase [2] sync [3] parity, sticky
//  parity        : running XOR of the current subframe's parity field
//  load_ch       : one-cycle pulse per completed channel subframe
//  load_buff     : one-cycle pulse every BUFF_EVERY frames
//  block_done    : one-cycle pulse after the last frame of a block
//  shift_reg     : last DATA_W bits received, newest at LSB
//  frame_ofs     : frame counter LSBs
module daio_rx_framer
    import daio_pkg::*;
#(
    parameter int unsigned DATA_W           = 20,
    parameter int unsigned SUBFRAME_BITS    = 32,
    parameter int unsigned PREAMBLE_BITS    = 4,
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned FRAMES_PER_BLOCK = 192,
    parameter int unsigned BUFF_EVERY       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_enable,
    input  logic              parity_enable,
    input  logic              status_clear,
    daio_rx_framer_if.slave   rx,
    output logic [STAT_W-1:0] rx_status,
    output logic              parity,
    output logic [NUM_CH-1:0] load_ch,
    output logic              load_buff,
    output logic              block_done,
    output logic [DATA_W-1:0] shift_reg,
    output logic [1:0]        frame_ofs
);

    localparam int unsigned BIT_W   = $clog2(SUBFRAME_BITS);
    localparam int unsigned FRAME_W = $clog2(FRAMES_PER_BLOCK);
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t             state;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CH_W-1:0]    ch;
    logic [FRAME_W-1:0] frame_cnt;

    logic              strobe_c;
    logic              last_bit_c;
    logic              last_ch_c;
    logic              last_frame_c;
    logic              buff_hit_c;
    logic              pre_exp_c;
    logic [STAT_W-1:0] stat_set_c;

    // Position decode and status set requests for the current strobe
    always_comb begin
        strobe_c     = rx_enable && (state == RECV) && !rx.carrier_loss && rx.bit_valid;
        last_bit_c   = (bit_cnt == BIT_W'(SUBFRAME_BITS - 1));
        last_ch_c    = (ch == CH_W'(NUM_CH - 1));
        last_frame_c = (frame_cnt == FRAME_W'(FRAMES_PER_BLOCK - 1));
        buff_hit_c   = ((32'(frame_cnt) % BUFF_EVERY) == (BUFF_EVERY - 1));

        // Block preamble only opens frame 0; later frames use A on channel 0
        if (ch == '0) begin
            pre_exp_c = (frame_cnt == '0) ? rx.preamble_block : rx.preamble_a;
        end else begin
            pre_exp_c = rx.preamble_b;
        end

        stat_set_c               = '0;
        stat_set_c[STAT_CARRIER] = rx.carrier_loss && (state != IDLE);
        stat_set_c[STAT_BIPHASE] = rx.biphase_violation && (state != IDLE);
        stat_set_c[STAT_SYNC]    = strobe_c && (bit_cnt == BIT_W'(PREAMBLE_BITS - 1)) && !pre_exp_c;
        stat_set_c[STAT_PARITY]  = strobe_c && last_bit_c && parity_enable && (parity ^ rx.bit_in);
    end

    // Framer FSM, position counters and registered strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            ch         <= '0;
            frame_cnt  <= '0;
            parity     <= 1'b0;
            shift_reg  <= '0;
            load_ch    <= '0;
            load_buff  <= 1'b0;
            block_done <= 1'b0;
        end else begin
            load_ch    <= '0;
            load_buff  <= 1'b0;
            block_done <= 1'b0;

            if (rx.bit_valid && (state != IDLE)) begin
                shift_reg <= {shift_reg[DATA_W-2:0], rx.bit_in};
            end

            if (!rx_enable) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                ch        <= '0;
                frame_cnt <= '0;
                parity    <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= SEEK;

                    // The block preamble strobe is the last preamble bit of ch 0
                    SEEK: begin
                        if (rx.bit_valid && rx.preamble_block) begin
                            state     <= RECV;
                            bit_cnt   <= BIT_W'(PREAMBLE_BITS);
                            ch        <= '0;
                            frame_cnt <= '0;
                            parity    <= 1'b0;
                        end
                    end

                    RECV: begin
                        if (rx.carrier_loss) begin
                            // Abort drops the partial subframe without strobes
                            state     <= SEEK;
                            bit_cnt   <= '0;
                            ch        <= '0;
                            frame_cnt <= '0;
                        end else if (rx.bit_valid) begin
                            if (last_bit_c) begin
                                bit_cnt <= '0;
                                parity  <= parity ^ rx.bit_in;
                                load_ch <= NUM_CH'(1) << ch;
                                if (last_ch_c) begin
                                    ch         <= '0;
                                    load_buff  <= buff_hit_c;
                                    block_done <= last_frame_c;
                                    if (last_frame_c) begin
                                        state     <= SEEK;
                                        frame_cnt <= '0;
                                    end else begin
                                        frame_cnt <= frame_cnt + FRAME_W'(1);
                                    end
                                end else begin
                                    ch <= ch + CH_W'(1);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                if (bit_cnt == '0) begin
                                    parity <= 1'b0;
                                end else if (bit_cnt >= BIT_W'(PREAMBLE_BITS)) begin
                                    parity <= parity ^ rx.bit_in;
                                end
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign frame_ofs = frame_cnt[1:0];

    daio_rx_status u_status (
        .clock    (clock),
        .reset    (reset),
        .set_bits (stat_set_c),
        .clear    (status_clear),
        .status   (rx_status)
    );

endmodule
